pio_input_conditioner: RTL and testbench
========================================

# pio_input_conditioner

Debounces the board push-buttons and slide switches and packs them into the two 32-bit words read by the PCIe core's `keys` and `switches` PIOs. It sits directly upstream of those PIO inputs and drives them from registered outputs only. The host can count key presses and detect switch activity by polling. No write path or clear path from the host is needed.

## Interface
Parameters:
- `TICK_DIV`, default 50000: clock cycles per debounce tick (1 ms at 50 MHz); legal range ≥ 2.
- `STABLE_TICKS`, default 10: consecutive ticks an input must differ from its stable value before it is accepted; legal range ≥ 1.

Ports:
- `clk`  in  1: system clock; the single clock domain.
- `reset_n`  in  1: asynchronous, active-low reset.
- `key_n_in`  in  4: raw push-buttons, active-low, asynchronous to `clk`.
- `sw_in`  in  18: raw slide switches, asynchronous to `clk`.
- `keys_word`  out  32: to `keys_external_connection_export`.
- `sw_word`  out  32: to `switches_external_connection_export`.

## Operation
- Synchronisers:
  - Each raw bit passes through a 2-FF synchroniser.
  - Key flops reset to 1 (released). Switch flops reset to 0.
  - Keys are inverted after synchronisation, so a pressed key is 1 internally.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps.
  - `tick` is high for one cycle when the count equals TICK_DIV-1.
  - One prescaler is shared by all 22 bits.
- Per-bit debounce (22 instances). Each instance holds a `stable` value and a counter `cnt` of width clog2(STABLE_TICKS+1). On each clock:
  - If sync == stable: cnt <= 0.
  - Else, on a `tick` with cnt == STABLE_TICKS-1: stable <= sync and cnt <= 0.
  - Else, on any other `tick`: cnt <= cnt+1.
  - Without a tick, cnt holds.
  - A glitch that returns to the stable value before acceptance clears cnt.
- Key press counters:
  - One 4-bit counter per key.
  - Increments when that key's debounced stable value goes 0→1.
  - Wraps 15→0.
  - Simultaneous presses on different keys each increment their own counter.
- Switch change counter:
  - 14 bits wide.
  - Increments by exactly 1 in any cycle where one or more debounced switch bits change.
  - Wraps 16383→0.
- `keys_word` fields:
  - [3:0] debounced key state, active-high.
  - [19:4] press counters; key i occupies [4i+7:4i+4].
  - [31:20] = 0.
- `sw_word` fields:
  - [17:0] debounced switch state.
  - [31:18] switch change counter.
- Reset mid-operation: every register returns to its reset value immediately. No press or change events are generated by reset itself.

## Timing
- Reset values:
  - `keys_word` = 0x00000000.
  - `sw_word` = 0x00000000.
  - Prescaler = 0, all `cnt` = 0, all `stable` = 0 (active-high domain).
- Output words are registered.
  - A debounced change appears on the outputs 1 cycle after `stable` updates.
  - The counter fields update in that same cycle.
- Latency from a raw edge to the output, for an input held steady throughout:
  - 2 synchroniser cycles, plus
  - STABLE_TICKS tick events (the first tick counted is the first one after the synchronised mismatch), plus
  - 1 output register cycle.
  - Range: 2 + (STABLE_TICKS-1)·TICK_DIV + 2 to 2 + STABLE_TICKS·TICK_DIV + 1 cycles.
- A bit that toggles faster than STABLE_TICKS ticks is never accepted.

## Configuration
- `PIO_COND_PRESS_COUNT_EN`:
  - Defined: the four key press counters exist and populate `keys_word[19:4]`.
  - Undefined: the counters are not instantiated and `keys_word[19:4]` is tied to 0.
  - Debounced key state and all `sw_word` behaviour are identical in both builds.

## Structure
- Shared package `pio_cond_pkg` holds:
  - Constants: `N_KEYS` = 4, `N_SW` = 18, `PRESS_CNT_W` = 4, `SW_CHG_W` = 14.
  - Field-offset constants for both words.
- Sub-module `debounce_bit`:
  - Contains the synchroniser, `cnt` and `stable` for one bit.
  - Reset value of the synchroniser is a parameter.
  - Takes `tick` as an input.
  - Instantiated 22 times.
- Top level holds the prescaler, the edge detection, the counters and the output packing.

## Test plan
Unless stated otherwise, run with TICK_DIV=4 and STABLE_TICKS=3.
- Reset check: assert reset_n=0 with key_n_in=4'hF and sw_in=0, then release. Both words must read 0x00000000 and stay there for 100 cycles.
- Clean key press: drive key_n_in[1]=0 and hold. `keys_word` must become 0x00000102 (key state bit1 set, key1 press counter = 1) within 2+12+1 cycles and not before 2+8+2 cycles. Releasing key 1 must clear bit 1 while the counter stays 1.
- Bounce rejection: toggle sw_in[5] every 6 cycles for 200 cycles, then hold it at 1.
  - No change is accepted during the toggling.
  - After settling, `sw_word` must read 0x00040020 (bit 5 set, change counter = 1).
- Simultaneous switch changes: set sw_in[0], sw_in[9] and sw_in[17] in the same cycle. `sw_word[17:0]` must read 0x20201 and the change counter must increment by exactly 1.
- Counter wrap: press and release key 3 sixteen times. `keys_word[19:16]` must step 1..15 and then read 0.
- Build without the macro: repeat the clean key press scenario with `PIO_COND_PRESS_COUNT_EN` undefined. `keys_word` must read 0x00000002.

Source files
------------

// File: rtl/pio_cond_pkg.sv
// Shared widths and field layout for the keys/switches PIO words.
package pio_cond_pkg;
  localparam int N_KEYS      = 4;
  localparam int N_SW        = 18;
  localparam int PRESS_CNT_W = 4;
  localparam int SW_CHG_W    = 14;

  localparam int KEY_STATE_LSB = 0;
  localparam int KEY_CNT_LSB   = 4;
  localparam int KEY_PAD_LSB   = KEY_CNT_LSB + N_KEYS*PRESS_CNT_W;
  localparam int KEY_PAD_W     = 32 - KEY_PAD_LSB;
  localparam int SW_STATE_LSB  = 0;
  localparam int SW_CHG_LSB    = N_SW;

  typedef struct packed {
    logic [KEY_PAD_W-1:0]                    pad;
    logic [N_KEYS-1:0][PRESS_CNT_W-1:0]      cnt;
    logic [N_KEYS-1:0]                       state;
  } keys_word_t;

  typedef struct packed {
    logic [SW_CHG_W-1:0] chg;
    logic [N_SW-1:0]     state;
  } sw_word_t;
endpackage

// File: rtl/debounce_bit.sv
// One input bit: 2-FF synchroniser plus tick-based acceptance counter.
module debounce_bit #(
  parameter logic SYNC_RST     = 1'b0,
  parameter bit   INVERT       = 1'b0,
  parameter int   STABLE_TICKS = 10
) (
  input  logic clk,
  input  logic reset_n,
  input  logic tick,
  input  logic raw,
  output logic stable
);
  localparam int            CW       = $clog2(STABLE_TICKS + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

  logic [1:0]    sync_ff;
  logic          sync;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) sync_ff <= {2{SYNC_RST}};
    else          sync_ff <= {sync_ff[0], raw};

  // Inversion after the synchroniser keeps the reset value in the raw domain.
  assign sync = sync_ff[1] ^ INVERT;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt    <= '0;
      stable <= 1'b0;
    end else if (sync == stable) begin
      cnt <= '0;
    end else if (tick) begin
      if (cnt == CNT_LAST) begin
        stable <= sync;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end
endmodule

// File: rtl/pio_input_conditioner.sv
// Debounces keys/switches and packs the PIO words; press counters exist only
// when PIO_COND_PRESS_COUNT_EN is defined.
module pio_input_conditioner
  import pio_cond_pkg::*;
#(
  parameter int TICK_DIV     = 50000,
  parameter int STABLE_TICKS = 10
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [N_KEYS-1:0] key_n_in,
  input  logic [N_SW-1:0]   sw_in,
  output logic [31:0]       keys_word,
  output logic [31:0]       sw_word
);
  localparam int PW = $clog2(TICK_DIV);

  logic [PW-1:0]                      pre;
  logic                               tick;
  logic [N_KEYS-1:0]                  key_stb, key_q;
  logic [N_SW-1:0]                    sw_stb, sw_q;
  logic [N_KEYS-1:0][PRESS_CNT_W-1:0] press_cnt;
  logic [SW_CHG_W-1:0]                sw_chg;
  keys_word_t                         kw;
  sw_word_t                           sw;

  assign tick = (pre == PW'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n)  pre <= '0;
    else if (tick) pre <= '0;
    else           pre <= pre + PW'(1);

  debounce_bit #(.SYNC_RST(1'b1), .INVERT(1'b1), .STABLE_TICKS(STABLE_TICKS))
    u_key_db [N_KEYS-1:0] (
      .clk(clk), .reset_n(reset_n), .tick(tick), .raw(key_n_in), .stable(key_stb));

  debounce_bit #(.SYNC_RST(1'b0), .INVERT(1'b0), .STABLE_TICKS(STABLE_TICKS))
    u_sw_db [N_SW-1:0] (
      .clk(clk), .reset_n(reset_n), .tick(tick), .raw(sw_in), .stable(sw_stb));

  // The state registers double as the previous value for edge detection,
  // so counters and state fields move on the same output edge.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      key_q  <= '0;
      sw_q   <= '0;
      sw_chg <= '0;
    end else begin
      key_q  <= key_stb;
      sw_q   <= sw_stb;
      sw_chg <= sw_chg + SW_CHG_W'(|(sw_stb ^ sw_q));
    end

`ifdef PIO_COND_PRESS_COUNT_EN
  logic [N_KEYS-1:0] key_rise;
  assign key_rise = key_stb & ~key_q;

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) press_cnt <= '0;
    else
      for (int i = 0; i < N_KEYS; i++)
        press_cnt[i] <= press_cnt[i] + PRESS_CNT_W'(key_rise[i]);
`else
  assign press_cnt = '0;
`endif

  always_comb begin
    kw       = '0;
    kw.cnt   = press_cnt;
    kw.state = key_q;
    sw       = '0;
    sw.chg   = sw_chg;
    sw.state = sw_q;
  end

  assign keys_word = kw;
  assign sw_word   = sw;
endmodule

// File: tb/tb_pio_input_conditioner.sv
// Directed bench for pio_input_conditioner with a timing-rule model (TICK_DIV=4, STABLE_TICKS=3).
module tb_pio_input_conditioner;
  localparam int TD = 4;
  localparam int ST = 3;
`ifdef PIO_COND_PRESS_COUNT_EN
  localparam logic [31:0] EXP_PRESS = 32'h0000_0102;
  localparam logic [31:0] EXP_REL   = 32'h0000_0100;
  localparam bit          CNT_EN    = 1'b1;
`else
  localparam logic [31:0] EXP_PRESS = 32'h0000_0002;
  localparam logic [31:0] EXP_REL   = 32'h0000_0000;
  localparam bit          CNT_EN    = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  key_n_in;
  logic [17:0] sw_in;
  logic [31:0] keys_word, sw_word;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pio_input_conditioner #(.TICK_DIV(TD), .STABLE_TICKS(ST)) dut (
    .clk(clk), .reset_n(reset_n), .key_n_in(key_n_in), .sw_in(sw_in),
    .keys_word(keys_word), .sw_word(sw_word));

  // Model: bit b (keys active-high in [3:0], switches in [21:4]) is accepted at a
  // tick edge once its synchronised value has differed from the accepted value
  // continuously across ST tick edges; edge e after reset is a tick iff e%TD==0.
  int          m_e = 0;
  int          m_mis[22];
  logic [21:0] m_r1 = '0, m_r2 = '0, m_stab = '0, m_out = '0, new_out;
  logic [3:0]  m_kc[4];
  logic [13:0] m_swc = '0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_e = 0; m_r1 = '0; m_r2 = '0; m_stab = '0; m_out = '0; m_swc = '0;
      for (int b = 0; b < 22; b++) m_mis[b] = 0;
      for (int k = 0; k < 4; k++)  m_kc[k] = '0;
    end else begin
      m_e++;
      new_out = m_stab;
      for (int k = 0; k < 4; k++)
        if (CNT_EN && new_out[k] && !m_out[k]) m_kc[k] = m_kc[k] + 4'd1;
      if (new_out[21:4] != m_out[21:4]) m_swc = m_swc + 14'd1;
      m_out = new_out;
      for (int b = 0; b < 22; b++) begin
        if (m_r2[b] != m_stab[b]) begin
          if (m_mis[b] == 0) m_mis[b] = m_e;
          if ((m_e % TD == 0) && (m_e/TD - (m_mis[b]-1)/TD >= ST)) begin
            m_stab[b] = m_r2[b];
            m_mis[b]  = 0;
          end
        end else m_mis[b] = 0;
      end
      m_r2 = m_r1;
      m_r1 = {sw_in, ~key_n_in};
    end
  end

  function automatic logic [31:0] exp_keys();
    return {12'h000, m_kc[3], m_kc[2], m_kc[1], m_kc[0], m_out[3:0]};
  endfunction

  always @(posedge clk) begin
    #1;
    total++;
    if (keys_word !== exp_keys() || sw_word !== {m_swc, m_out[21:4]}) begin
      bad++;
      $display("FAIL model t=%0t keys got %08h want %08h sw got %08h want %08h",
               $time, keys_word, exp_keys(), sw_word, {m_swc, m_out[21:4]});
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h want %08h", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    #1 chk("reset_immediate_keys", keys_word, 32'h0);
    chk("reset_immediate_sw", sw_word, 32'h0);
    cyc(2);
    reset_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit found;
    key_n_in = 4'hF;
    sw_in    = '0;
    reset_n  = 1'b0;
    cyc(3);
    reset_n = 1'b1;

    for (int i = 0; i < 100; i++) begin
      cyc(1);
      chk("reset_keys", keys_word, 32'h0);
      chk("reset_sw", sw_word, 32'h0);
    end

    // Clean key-1 press with latency window.
    key_n_in = 4'b1101;
    n = 0; found = 0;
    while (!found && n < 40) begin
      @(posedge clk); #1; n++;
      if (keys_word == EXP_PRESS) found = 1;
    end
    total++;
    if (!found || n < 12 || n > 15) begin
      bad++;
      $display("FAIL press_latency: got %0d cycles (found=%0d) want 12..15", n, found);
    end
    @(negedge clk);
    chk("press_value", keys_word, EXP_PRESS);
    key_n_in = 4'hF;
    cyc(20);
    chk("release_value", keys_word, EXP_REL);

    cyc(1);
    pulse_reset();
    cyc(30);
    chk("post_reset_keys", keys_word, 32'h0);
    chk("post_reset_sw", sw_word, 32'h0);

    // Bounce on sw[5]: 6-cycle half period is shorter than 3 ticks.
    for (int i = 0; i < 200; i++) begin
      if (i % 6 == 0) sw_in[5] = ~sw_in[5];
      cyc(1);
      chk("bounce_reject", sw_word, 32'h0);
    end
    sw_in[5] = 1'b1;
    cyc(20);
    chk("bounce_settled", sw_word, 32'h0004_0020);

    sw_in = '0;
    cyc(20);
    pulse_reset();
    cyc(20);
    chk("sim_pre", sw_word, 32'h0);

    // Three switches together: one change event.
    sw_in = 18'h20201;
    n = 0; found = 0;
    while (!found && n < 40) begin
      @(posedge clk); #1; n++;
      if (sw_word[17:0] != 18'h0) found = 1;
    end
    chk("sim_first_change", sw_word, 32'h0006_0201);
    cyc(20);
    chk("sim_settled", sw_word, 32'h0006_0201);

    // Key 3 press counter wrap.
    for (int k = 1; k <= 16; k++) begin
      key_n_in = 4'b0111;
      cyc(20);
      chk("wrap_press", keys_word, CNT_EN ? ({12'h0, 4'(k % 16), 12'h000, 4'h8}) : 32'h8);
      key_n_in = 4'hF;
      cyc(20);
      chk("wrap_release", keys_word, CNT_EN ? ({12'h0, 4'(k % 16), 16'h0000}) : 32'h0);
    end
    chk("wrap_final", keys_word, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
